span_fragment_emitter: RTL and testbench
========================================

# span_fragment_emitter

Producer side of the z-buffer fragment queue: takes one horizontal span per handshake (y, x range, start depth, per-pixel depth step, colour), clips it to the screen, and pushes one 256-bit fragment entry per pixel into `zbuffer_queue` in the layout the z-buffer stage unpacks. It sits between the rasterization-stage processor output and the z-buffer queue, and replaces direct register-file pushes for span fill.

## Interface
Parameters:
- `WIDTH`, 640, screen width in pixels; valid x is 0..WIDTH-1.
- `HEIGHT`, 480, screen height in pixels; valid y is 0..HEIGHT-1.
- `QDEPTH`, 1024, capacity of the downstream queue in entries.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `span_valid`  in  1  a span is offered.
- `span_ready`  out  1  the block accepts a span this cycle.
- `span_y`  in  16  signed row.
- `span_x0`, `span_x1`  in  16 each  signed inclusive first and last column.
- `span_z0`  in  16  unsigned depth at `span_x0`.
- `span_dz`  in  16  signed depth step per pixel.
- `span_rgb`  in  24  {red, green, blue}, 8 bits each.
- `q_size`  in  16  current downstream queue occupancy.
- `q_adding`  out  1  push strobe into the queue; one entry per high cycle.
- `q_add_regs`  out  256  fragment entry.
- `busy`  out  1  high in any state other than IDLE.
- `frag_count`  out  32  total fragments pushed since reset; wraps.

## Operation
- States: IDLE, SETUP, EMIT.
- IDLE
  - `span_ready`=1.
  - On `span_valid`&`span_ready`: capture all span fields, go to SETUP.
- SETUP (one cycle)
  - xs = max(x0, 0); xe = min(x1, WIDTH-1).
  - zs = z0 + dz*(xs-x0), computed at 34-bit signed width.
  - Empty span (y<0, y>=HEIGHT, or xs>xe): go to IDLE, push nothing. This includes x0>x1 and spans entirely off-screen.
  - Otherwise: load cur_x=xs and cur_z=zs, go to EMIT.
- EMIT
  - Room = (q_size + 2 < QDEPTH).
  - When there is room, push one fragment for cur_x, then cur_x+=1 and cur_z+=dz.
  - When cur_x==xe is pushed, go to IDLE. Otherwise stay in EMIT.
  - When there is no room, hold cur_x and cur_z and push nothing.
- Depth arithmetic
  - cur_z is held at 18-bit signed width.
  - The emitted z is clamped to 0..16'hFFFE. 16'hFFFF is the z-buffer clear value and must never be written.
- Fragment layout (all other bits zero)
  - [255:240] x
  - [239:224] y
  - [223:208] z
  - [63:48] {8'h00, red}
  - [47:32] {8'h00, green}
  - [31:16] {8'h00, blue}
- `frag_count` increments by one per `q_adding` cycle.

## Timing
- Reset values: state=IDLE, `span_ready`=1, `q_adding`=0, `q_add_regs`=0, `busy`=0, `frag_count`=0.
- Reset mid-span: the span is abandoned and no further pushes occur. Entries already pushed stay in the queue.
- `q_adding` and `q_add_regs` are registered.
  - For a span accepted at edge E0, SETUP occupies the cycle after E0.
  - The first `q_adding` is high in the cycle after E2, i.e. two edges after acceptance.
- Throughput: one fragment per cycle while room holds.
- Per-span overhead: one SETUP cycle, plus one IDLE cycle before the next acceptance.
- `span_ready` is low in SETUP and EMIT. There is no span queueing.
- Room margin of 2 covers the one-cycle registered push plus the one-cycle `q_size` update latency. The queue must never overflow for any `q_size` trajectory.
- `q_adding` is never high for two pushes of the same x.
- `q_adding` is low in every cycle that is not a push.

## Structure
- Shared package:
  - fragment field bit positions (X_HI..BLUE_LO);
  - the z clear value 16'hFFFF and the max writable z 16'hFFFE;
  - screen constants 640/480.
- The z-buffer consumer uses the same package.
- One natural sub-module: `span_clip`, the combinational SETUP math producing xs, xe, zs and empty.

## Test plan
- Basic span: y=10, x0=5, x1=8, z0=100, dz=3, rgb=0x112233 → four pushes with x=5..8, z=100,103,106,109, red field 0x0011. The first push is two edges after acceptance; `frag_count`=4.
- Left clip with depth: x0=-3, x1=1, z0=50, dz=10 → pushes x=0,1 with z=80,90.
- Right clip: x0=638, x1=700 → pushes x=638,639 only.
- Empty spans: x0=9, x1=4; and y=480 → no push, `busy` high for exactly one cycle.
- Depth clamp: z0=0xFFF0, dz=8 → z=0xFFF0, 0xFFF8, 0xFFFE, 0xFFFE. A negative dz driving below zero → z=0.
- Backpressure and reset:
  - Hold q_size=QDEPTH-2 mid-span → pushes stop within one cycle. Release → the sequence resumes at the next x with no gap or repeat.
  - Assert rst_n=0 mid-span → `q_adding`=0 immediately and state is IDLE.

Source files
------------

// File: rtl/span_fragment_emitter_pkg.sv
// Shared definitions for the span fragment producer and the z-buffer consumer:
// fragment bit layout, depth limits, screen size and the emitter FSM encoding.
package span_fragment_emitter_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam logic [15:0] Z_CLEAR = 16'hFFFF;
    localparam logic [15:0] Z_MAX   = 16'hFFFE;

    localparam int X_HI     = 255;
    localparam int X_LO     = 240;
    localparam int Y_HI     = 239;
    localparam int Y_LO     = 224;
    localparam int Z_HI     = 223;
    localparam int Z_LO     = 208;
    localparam int RED_HI   = 63;
    localparam int RED_LO   = 48;
    localparam int GREEN_HI = 47;
    localparam int GREEN_LO = 32;
    localparam int BLUE_HI  = 31;
    localparam int BLUE_LO  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] y;
        logic [15:0] x0;
        logic [15:0] x1;
        logic [15:0] z0;
        logic [15:0] dz;
        logic [23:0] rgb;
    } span_t;

    // Z_CLEAR is reserved for "no fragment", so writable depth tops out at Z_MAX.
    function automatic logic [15:0] clamp_z(input logic signed [17:0] z);
        logic [15:0] r;
        if (z < 18'sd0) begin
            r = 16'h0000;
        end else if (z > $signed({2'b00, Z_MAX})) begin
            r = Z_MAX;
        end else begin
            r = z[15:0];
        end
        return r;
    endfunction

    function automatic logic [255:0] build_frag(input logic [15:0] x, input logic [15:0] y,
                                                input logic [15:0] z, input logic [23:0] rgb);
        logic [255:0] f;
        f = '0;
        f[X_HI:X_LO]         = x;
        f[Y_HI:Y_LO]         = y;
        f[Z_HI:Z_LO]         = z;
        f[RED_HI:RED_LO]     = {8'h00, rgb[23:16]};
        f[GREEN_HI:GREEN_LO] = {8'h00, rgb[15:8]};
        f[BLUE_HI:BLUE_LO]   = {8'h00, rgb[7:0]};
        return f;
    endfunction

endpackage

// File: rtl/span_fragment_emitter_span_clip.sv
// Combinational span clipping: screen-clipped column range, depth at the first
// visible column, and whether anything of the span is left to draw.
module span_fragment_emitter_span_clip
    import span_fragment_emitter_pkg::*;
#(
    parameter int WIDTH  = SCREEN_W,
    parameter int HEIGHT = SCREEN_H
) (
    input  logic signed [15:0] y,
    input  logic signed [15:0] x0,
    input  logic signed [15:0] x1,
    input  logic        [15:0] z0,
    input  logic signed [15:0] dz,
    output logic signed [15:0] xs,
    output logic signed [15:0] xe,
    output logic signed [33:0] zs,
    output logic               empty
);

    localparam logic signed [16:0] X_LAST = 17'(WIDTH - 1);
    localparam logic signed [16:0] Y_LIM  = 17'(HEIGHT);

    logic signed [16:0] y_e;
    logic signed [16:0] x0_e;
    logic signed [16:0] x1_e;
    logic signed [16:0] diff;
    logic signed [33:0] dz_e;
    logic signed [33:0] diff_e;
    logic signed [33:0] z0_e;

    always_comb begin
        y_e  = 17'(y);
        x0_e = 17'(x0);
        x1_e = 17'(x1);
        xs   = (x0_e < 17'sd0) ? 16'sd0 : x0;
        xe   = (x1_e > X_LAST) ? X_LAST[15:0] : x1;
        diff = 17'(xs) - x0_e;
        // 34 bits holds z0 plus the worst-case dz * (left-clip distance).
        dz_e   = 34'(dz);
        diff_e = 34'(diff);
        z0_e   = $signed({18'd0, z0});
        zs     = z0_e + dz_e * diff_e;
        empty  = (y_e < 17'sd0) || (y_e >= Y_LIM) || (xs > xe);
    end

endmodule

// File: rtl/span_fragment_emitter.sv
// Turns one accepted horizontal span into a stream of clipped, depth-clamped
// 256-bit fragment pushes into the z-buffer queue, throttled by queue occupancy.
module span_fragment_emitter
    import span_fragment_emitter_pkg::*;
#(
    parameter int WIDTH  = SCREEN_W,
    parameter int HEIGHT = SCREEN_H,
    parameter int QDEPTH = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         span_valid,
    output logic         span_ready,
    input  logic [15:0]  span_y,
    input  logic [15:0]  span_x0,
    input  logic [15:0]  span_x1,
    input  logic [15:0]  span_z0,
    input  logic [15:0]  span_dz,
    input  logic [23:0]  span_rgb,
    input  logic [15:0]  q_size,
    output logic         q_adding,
    output logic [255:0] q_add_regs,
    output logic         busy,
    output logic [31:0]  frag_count
);

    // span handshake: a span transfers on any rising edge where span_valid and
    // span_ready are both high; span_ready is high only in IDLE, so at most one
    // span is in flight and the producer must hold its fields until that edge.

    state_t state_q, state_d;

    span_t               span_q, span_d;
    logic signed [15:0]  cur_x_q, cur_x_d;
    logic signed [15:0]  xe_q, xe_d;
    logic signed [17:0]  cur_z_q, cur_z_d;
    logic                q_adding_q, q_adding_d;
    logic [255:0]        q_add_regs_q, q_add_regs_d;
    logic [31:0]         frag_count_q, frag_count_d;

    logic signed [15:0]  clip_xs;
    logic signed [15:0]  clip_xe;
    logic signed [33:0]  clip_zs;
    logic                clip_empty;

    logic [31:0]         q_need;
    logic                room;
    logic                push;
    logic                last_x;

    span_fragment_emitter_span_clip #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_span_clip (
        .y     (span_q.y),
        .x0    (span_q.x0),
        .x1    (span_q.x1),
        .z0    (span_q.z0),
        .dz    (span_q.dz),
        .xs    (clip_xs),
        .xe    (clip_xe),
        .zs    (clip_zs),
        .empty (clip_empty)
    );

    // Margin of 2: one entry may already be in the push register and q_size
    // lags that push by a cycle.
    assign q_need = 32'(q_size) + 32'd2;
    assign room   = q_need < 32'(QDEPTH);
    assign last_x = (cur_x_q == xe_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (span_valid) state_d = ST_SETUP;
            ST_SETUP: state_d = clip_empty ? ST_IDLE : ST_EMIT;
            ST_EMIT:  if (push && last_x) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        span_ready = (state_q == ST_IDLE);
        busy       = (state_q != ST_IDLE);
        push       = (state_q == ST_EMIT) && room;
    end

    always_comb begin
        span_d       = span_q;
        cur_x_d      = cur_x_q;
        xe_d         = xe_q;
        cur_z_d      = cur_z_q;
        q_adding_d   = push;
        q_add_regs_d = q_add_regs_q;
        frag_count_d = frag_count_q + 32'(push);
        if (span_ready && span_valid) begin
            span_d = '{y: span_y, x0: span_x0, x1: span_x1,
                       z0: span_z0, dz: span_dz, rgb: span_rgb};
        end
        if ((state_q == ST_SETUP) && !clip_empty) begin
            cur_x_d = clip_xs;
            xe_d    = clip_xe;
            cur_z_d = clip_zs[17:0];
        end
        if (push) begin
            q_add_regs_d = build_frag(cur_x_q, span_q.y, clamp_z(cur_z_q), span_q.rgb);
            cur_x_d      = cur_x_q + 16'sd1;
            cur_z_d      = cur_z_q + 18'($signed(span_q.dz));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            span_q       <= '0;
            cur_x_q      <= '0;
            xe_q         <= '0;
            cur_z_q      <= '0;
            q_adding_q   <= 1'b0;
            q_add_regs_q <= '0;
            frag_count_q <= '0;
        end else begin
            span_q       <= span_d;
            cur_x_q      <= cur_x_d;
            xe_q         <= xe_d;
            cur_z_q      <= cur_z_d;
            q_adding_q   <= q_adding_d;
            q_add_regs_q <= q_add_regs_d;
            frag_count_q <= frag_count_d;
        end
    end

    assign q_adding   = q_adding_q;
    assign q_add_regs = q_add_regs_q;
    assign frag_count = frag_count_q;

endmodule

// File: tb/tb_span_fragment_emitter.sv
// Bench for span_fragment_emitter: directed spans from the test plan, then
// random spans with random queue occupancy, against a per-pixel formula model.
module tb_span_fragment_emitter;

    localparam int W      = 640;
    localparam int H      = 480;
    localparam int QDEPTH = 1024;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         span_valid;
    logic         span_ready;
    logic [15:0]  span_y, span_x0, span_x1, span_z0, span_dz;
    logic [23:0]  span_rgb;
    logic [15:0]  q_size = '0;
    logic         q_adding;
    logic [255:0] q_add_regs;
    logic         busy;
    logic [31:0]  frag_count;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [255:0] exp_q[$];
    logic [31:0]  exp_count = '0;
    logic         bp_rand = 1'b0;
    logic [15:0]  q_size_fixed = '0;
    int           last_qs = 0;

    span_fragment_emitter #(.WIDTH(W), .HEIGHT(H), .QDEPTH(QDEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .span_valid (span_valid),
        .span_ready (span_ready),
        .span_y     (span_y),
        .span_x0    (span_x0),
        .span_x1    (span_x1),
        .span_z0    (span_z0),
        .span_dz    (span_dz),
        .span_rgb   (span_rgb),
        .q_size     (q_size),
        .q_adding   (q_adding),
        .q_add_regs (q_add_regs),
        .busy       (busy),
        .frag_count (frag_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk_frag(input int x, input int y, input int z, input logic [23:0] rgb);
        logic [15:0] xv, yv, zv;
        xv = 16'(x);
        yv = 16'(y);
        zv = 16'(z);
        return {xv, yv, zv, 144'd0, 8'h00, rgb[23:16], 8'h00, rgb[15:8], 8'h00, rgb[7:0], 16'd0};
    endfunction

    // Reference: every visible pixel gets z0 + dz*(x - x0), clamped to 0..FFFE.
    task automatic model_span(input int y, input int x0, input int x1, input int z0, input int dz,
                              input logic [23:0] rgb);
        int xs, xe, z;
        xs = (x0 < 0) ? 0 : x0;
        xe = (x1 > W - 1) ? W - 1 : x1;
        if (y < 0 || y >= H || xs > xe) return;
        for (int x = xs; x <= xe; x++) begin
            z = z0 + dz * (x - x0);
            if (z < 0) z = 0;
            if (z > 65534) z = 65534;
            exp_q.push_back(mk_frag(x, y, z, rgb));
            exp_count++;
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (bp_rand) begin
            if ($urandom_range(0, 9) < 3) q_size = 16'(QDEPTH - 3 + int'($urandom_range(0, 2)));
            else q_size = 16'($urandom_range(0, 900));
        end else begin
            q_size = q_size_fixed;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && q_adding === 1'b1) begin
            check("room_margin", 256'(last_qs + 2 < QDEPTH), 256'(1));
            if (exp_q.size() == 0) check("spurious_push", 256'(q_adding), 256'(0));
            else check("frag", q_add_regs, exp_q.pop_front());
        end
        last_qs = int'(q_size);
    end

    // Offers a span and returns just after the accepting edge.
    task automatic send_span(input int y, input int x0, input int x1, input int z0, input int dz,
                             input logic [23:0] rgb);
        @(negedge clk);
        span_y = 16'(y); span_x0 = 16'(x0); span_x1 = 16'(x1);
        span_z0 = 16'(z0); span_dz = 16'(dz); span_rgb = rgb;
        span_valid = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            if (span_ready) break;
            @(negedge clk);
        end
        check("accept_ready", 256'(span_ready), 256'(1));
        @(posedge clk);
        model_span(y, x0, x1, z0, dz, rgb);
        #1 span_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            #1;
            if (!busy) break;
        end
        check("done_timeout", 256'(busy), 256'(0));
        check("leftover", 256'(exp_q.size()), 256'(0));
        check("frag_count", 256'(frag_count), 256'(exp_count));
    endtask

    task automatic wait_pushes(input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            if (q_adding) cnt++;
            if (cnt >= n) break;
        end
        check("pushes_seen", 256'(cnt), 256'(n));
    endtask

    initial begin
        int busy_cycles;
        int y, x0, x1;
        rst_n = 1'b0;
        span_valid = 1'b0;
        span_y = '0; span_x0 = '0; span_x1 = '0; span_z0 = '0; span_dz = '0; span_rgb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", 256'(span_ready), 256'(1));
        check("rst_adding", 256'(q_adding), 256'(0));
        check("rst_regs", q_add_regs, 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_count", 256'(frag_count), 256'(0));

        // Basic span with latency checks.
        send_span(10, 5, 8, 100, 3, 24'h112233);
        @(negedge clk);
        check("setup_busy", 256'(busy), 256'(1));
        check("setup_ready", 256'(span_ready), 256'(0));
        check("lat_e0", 256'(q_adding), 256'(0));
        @(negedge clk);
        check("lat_e1", 256'(q_adding), 256'(0));
        @(negedge clk);
        check("lat_e2", 256'(q_adding), 256'(1));
        wait_done();
        check("basic_count", 256'(frag_count), 256'(4));

        send_span(20, -3, 1, 50, 10, 24'hA0B0C0);
        wait_done();
        send_span(0, 638, 700, 7, 1, 24'h010203);
        wait_done();

        // Empty spans: busy exactly one cycle, nothing pushed.
        for (int k = 0; k < 2; k++) begin
            if (k == 0) send_span(5, 9, 4, 1, 1, 24'hFFFFFF);
            else send_span(480, 0, 10, 1, 1, 24'hFFFFFF);
            busy_cycles = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (busy) busy_cycles++;
            end
            check("empty_busy", 256'(busy_cycles), 256'(1));
            check("empty_count", 256'(frag_count), 256'(exp_count));
        end

        send_span(30, 0, 3, 16'hFFF0, 8, 24'h445566);
        wait_done();
        send_span(31, 0, 4, 20, -10, 24'h778899);
        wait_done();

        // Backpressure mid-span.
        send_span(40, 100, 119, 1000, -5, 24'h0F0E0D);
        wait_pushes(5);
        q_size_fixed = 16'(QDEPTH - 2);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_stall", 256'(q_adding), 256'(0));
        end
        q_size_fixed = '0;
        wait_done();

        // Reset mid-span.
        send_span(50, 0, 59, 10, 1, 24'h123456);
        wait_pushes(10);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_adding", 256'(q_adding), 256'(0));
        check("midrst_busy", 256'(busy), 256'(0));
        check("midrst_ready", 256'(span_ready), 256'(1));
        check("midrst_count", 256'(frag_count), 256'(0));
        exp_q.delete();
        exp_count = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("post_rst_idle", 256'(busy), 256'(0));

        // Random spans under random queue occupancy.
        bp_rand = 1'b1;
        for (int n = 0; n < 40; n++) begin
            y  = int'($urandom_range(0, 520)) - 20;
            x0 = int'($urandom_range(0, 840)) - 100;
            x1 = x0 + int'($urandom_range(0, 220)) - 20;
            send_span(y, x0, x1, int'($urandom_range(0, 65535)),
                      int'($urandom_range(0, 128)) - 64, 24'($urandom));
            wait_done();
        end
        bp_rand = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
